// File: rtl/key_debounce_pulse_if.sv
// Button-conditioner signal bundle: raw key in, debounced level/strobes out.
// master = key source / consumer side, slave = key_debounce_pulse.
interface key_debounce_pulse_if;
  logic KEY_IN;
  logic D_OUT;
  logic D_OUT_n;
  logic RISE_PULSE;
  logic FALL_PULSE;
  logic LONG_PRESS;

  modport master (
    output KEY_IN,
    input  D_OUT,
    input  D_OUT_n,
    input  RISE_PULSE,
    input  FALL_PULSE,
    input  LONG_PRESS
  );

  modport slave (
    input  KEY_IN,
    output D_OUT,
    output D_OUT_n,
    output RISE_PULSE,
    output FALL_PULSE,
    output LONG_PRESS
  );
endinterface

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM, rise/fall strobes.
// Optional long-hold detector enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned LONG_CYCLES     = 50000
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  key_debounce_pulse_if.slave   bus
);

  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && ((DEBOUNCE_CYCLES >> CNT_WIDTH) == 0) &&
                             (LONG_CYCLES >= 1) && ((LONG_CYCLES >> CNT_WIDTH) == 0);

  if (!PARAMS_OK) begin : g_param_check
    $error("key_debounce_pulse: DEBOUNCE_CYCLES/LONG_CYCLES out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  logic                 sync0_q;
  logic                 sync1_q;
  state_e               state_q,   state_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 d_out_q,   d_out_d;
  logic                 d_out_n_q, d_out_n_d;
  logic                 rise_q,    rise_d;
  logic                 fall_q,    fall_d;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_SAT  = CNT_WIDTH'(LONG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 long_q, long_d;
`endif

  // Metastability filter for the asynchronous key; FSM sees only sync1_q.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= bus.KEY_IN;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      d_out_q   <= 1'b0;
      d_out_n_q <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_out_q   <= d_out_d;
      d_out_n_q <= d_out_n_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
`endif

  // Next-state logic; strobes default low so they last exactly one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_out_d   = d_out_q;
    d_out_n_d = d_out_n_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    hold_d    = hold_q;
    long_d    = long_q;
`endif

    unique case (state_q)
      IDLE_LOW: begin
        if (sync1_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        // A revert on the final count cycle still counts as a bounce.
        if (!sync1_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_HIGH;
          cnt_d     = '0;
          d_out_d   = 1'b1;
          d_out_n_d = 1'b0;
          rise_d    = 1'b1;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
          hold_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!sync1_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        // Saturating hold count; the single match on HOLD_LAST makes it one-shot.
        if (hold_q < HOLD_SAT) begin
          hold_d = hold_q + CNT_ONE;
        end
        if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end
`endif
      end

      WAIT_LOW: begin
        if (sync1_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          d_out_d   = 1'b0;
          d_out_n_d = 1'b1;
          fall_d    = 1'b1;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
          long_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.D_OUT      = d_out_q;
  assign bus.D_OUT_n    = d_out_n_q;
  assign bus.RISE_PULSE = rise_q;
  assign bus.FALL_PULSE = fall_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  assign bus.LONG_PRESS = long_q;
`else
  assign bus.LONG_PRESS = 1'b0;
`endif

endmodule
